vec_cache_write_arbiter: RTL and testbench

Shares the single write port of the vector cache (`VecCache`) between two writers: requester 0 (vector ALU writeback) and requester 1 (load unit). Each requester uses a valid/ready handshake. The block grants one request per cycle by round-robin and registers the winner onto the cache write port. It also flags reads that would race an in-flight write, and counts issued writes.

---
 rtl/vec_cache_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_vec_cache_write_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_cache_write_arbiter.sv
// -----------------------------------------------------------------------------
// vec_cache_write_arbiter
//
// Shares the single write port of the vector cache between two writers:
// requester 0 (vector ALU writeback) and requester 1 (load unit). One request
// is granted per cycle by round-robin, and the winner is registered onto the
// cache write port. The block also flags reads that race the write currently
// on the port, and counts issued (non-DISABLE) writes.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   hold                  blocks all grants; output stage drains to DISABLE
//   reqN_valid/ready      valid/ready handshake per requester (N = 0, 1)
//   reqN_op/addr/param    write opcode, cache entry, lane index for SCALAR
//   reqN_data             WIDTH lanes of 32-bit IEEE-754 single, lane 0 in
//                         bits [31:0]; SCALAR writes use lane 0 only
//   write_op/addr/param   registered cache write command
//   data_in               registered cache write data
//   rd_addr               address used by the cache read port this cycle
//   rd_hazard             the read races the write currently on the port
//   writes_issued         wrapping count of non-DISABLE writes driven
// -----------------------------------------------------------------------------
package vec_cache_pkg;
    typedef enum logic [1:0] {
        VEC_DATA_WRITE_DISABLE = 2'd0,
        VEC_DATA_WRITE_VEC     = 2'd1,
        VEC_DATA_WRITE_SCALAR  = 2'd2
    } VecDataWriteOp_t;
endpackage

module vec_cache_write_arbiter
    import vec_cache_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int DW    = 32 * WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          hold,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_op,
    input  logic [AW-1:0] req0_addr,
    input  logic [AW-1:0] req0_param,
    input  logic [DW-1:0] req0_data,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_op,
    input  logic [AW-1:0] req1_addr,
    input  logic [AW-1:0] req1_param,
    input  logic [DW-1:0] req1_data,

    output logic [1:0]    write_op,
    output logic [AW-1:0] write_addr,
    output logic [AW-1:0] write_param,
    output logic [DW-1:0] data_in,

    input  logic [AW-1:0] rd_addr,
    output logic          rd_hazard,
    output logic [15:0]   writes_issued
);

    logic          grant;
    logic          grant_idx;

    logic          last_grant_q,    last_grant_d;
    logic [1:0]    write_op_q,      write_op_d;
    logic [AW-1:0] write_addr_q,    write_addr_d;
    logic [AW-1:0] write_param_q,   write_param_d;
    logic [DW-1:0] data_in_q,       data_in_d;
    logic [15:0]   writes_issued_q, writes_issued_d;

    // Grant: nothing while in reset or on hold; a lone requester always wins;
    // on contention the requester that did not win last time goes first.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        grant     = 1'b0;
        grant_idx = 1'b0;
        if (!reset && !hold) begin
            if (req0_valid && req1_valid) begin
                grant     = 1'b1;
                grant_idx = ~last_grant_q;
            end else if (req0_valid) begin
                grant     = 1'b1;
                grant_idx = 1'b0;
            end else if (req1_valid) begin
                grant     = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign req0_ready = grant && (grant_idx == 1'b0);
    assign req1_ready = grant && (grant_idx == 1'b1);

    // Next state of the output stage. Without a grant only the opcode drops to
    // DISABLE; address, param and data keep their last values.
    always_comb begin
        last_grant_d  = last_grant_q;
        write_op_d    = VEC_DATA_WRITE_DISABLE;
        write_addr_d  = write_addr_q;
        write_param_d = write_param_q;
        data_in_d     = data_in_q;
        if (grant) begin
            last_grant_d  = grant_idx;
            write_op_d    = grant_idx ? req1_op    : req0_op;
            write_addr_d  = grant_idx ? req1_addr  : req0_addr;
            write_param_d = grant_idx ? req1_param : req0_param;
            data_in_d     = grant_idx ? req1_data  : req0_data;
        end
        writes_issued_d = writes_issued_q
                        + {15'd0, (write_op_q != VEC_DATA_WRITE_DISABLE)};
    end

    always_ff @(posedge clock) begin
        // NOTE: state updates are non-blocking so every flop samples pre-edge values.
        if (reset) begin
            last_grant_q    <= 1'b1;   // requester 0 wins the first contention
            write_op_q      <= VEC_DATA_WRITE_DISABLE;
            write_addr_q    <= '0;
            write_param_q   <= '0;
            data_in_q       <= '0;
            writes_issued_q <= '0;
        end else begin
            last_grant_q    <= last_grant_d;
            write_op_q      <= write_op_d;
            write_addr_q    <= write_addr_d;
            write_param_q   <= write_param_d;
            data_in_q       <= data_in_d;
            writes_issued_q <= writes_issued_d;
        end
    end

    // While reset is high the pending write is masked, so the cache never
    // commits a write that was in flight when reset arrived.
    assign write_op      = reset ? VEC_DATA_WRITE_DISABLE : write_op_q;
    assign write_addr    = write_addr_q;
    assign write_param   = write_param_q;
    assign data_in       = data_in_q;
    assign writes_issued = writes_issued_q;

    // The cache has not committed the write on the port yet, so a read of the
    // same entry returns stale data regardless of which lane is written.
    assign rd_hazard = (write_op != VEC_DATA_WRITE_DISABLE) && (write_addr == rd_addr);

endmodule

// File: tb/tb_vec_cache_write_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for vec_cache_write_arbiter (WIDTH = 4). Inputs are driven on the
// falling edge; combinational outputs are sampled 1 ns later and registered
// outputs at the falling edge. A small cache model commits the write port on
// each rising edge, so reads can be checked the way the sequencer sees them.
// -----------------------------------------------------------------------------
module tb_vec_cache_write_arbiter;
    import vec_cache_pkg::*;

    localparam int WIDTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 32 * WIDTH;

    localparam logic [31:0] F9 = 32'h4110_0000;
    localparam logic [31:0] F7 = 32'h40E0_0000;
    localparam logic [31:0] F5 = 32'h40A0_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;

    logic          clock;
    logic          reset;
    logic          hold;
    logic          req0_valid, req0_ready;
    logic [1:0]    req0_op;
    logic [AW-1:0] req0_addr, req0_param;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [1:0]    req1_op;
    logic [AW-1:0] req1_addr, req1_param;
    logic [DW-1:0] req1_data;
    logic [1:0]    write_op;
    logic [AW-1:0] write_addr, write_param;
    logic [DW-1:0] data_in;
    logic [AW-1:0] rd_addr;
    logic          rd_hazard;
    logic [15:0]   writes_issued;

    int n_tests;
    int n_fail;

    logic [DW-1:0] cache_mem [WIDTH];

    vec_cache_write_arbiter #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .hold          (hold),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_op       (req0_op),
        .req0_addr     (req0_addr),
        .req0_param    (req0_param),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_op       (req1_op),
        .req1_addr     (req1_addr),
        .req1_param    (req1_param),
        .req1_data     (req1_data),
        .write_op      (write_op),
        .write_addr    (write_addr),
        .write_param   (write_param),
        .data_in       (data_in),
        .rd_addr       (rd_addr),
        .rd_hazard     (rd_hazard),
        .writes_issued (writes_issued)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cache model: commits whatever is on the write port at each rising edge.
    always @(posedge clock) begin
        if (write_op == VEC_DATA_WRITE_VEC)
            cache_mem[write_addr] <= data_in;
        else if (write_op == VEC_DATA_WRITE_SCALAR)
            cache_mem[write_addr][32*write_param +: 32] <= data_in[31:0];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DW-1:0] lanes(input logic [31:0] l0, input logic [31:0] l1,
                                            input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic apply_reset();
        reset = 1'b1; hold = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; rd_addr = '0;
        req0_valid = 1'b1; req0_op = VEC_DATA_WRITE_VEC; req0_addr = '0; req0_param = '0; req0_data = '1;
        req1_valid = 1'b1; req1_op = VEC_DATA_WRITE_VEC; req1_addr = '0; req1_param = '0; req1_data = '1;
        repeat (2) @(negedge clock);
        #1;
        n_tests++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %0b expected 0", req0_ready); end
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %0b expected 0", req1_ready); end
        n_tests++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %0b expected 0", rd_hazard); end
        n_tests++; if (write_op !== VEC_DATA_WRITE_DISABLE) begin n_fail++; $display("FAIL reset_op: got %0d expected 0", write_op); end
        n_tests++; if (write_addr !== '0 || write_param !== '0) begin n_fail++; $display("FAIL reset_addr_param: got %0d/%0d expected 0/0", write_addr, write_param); end
        n_tests++; if (data_in !== '0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", data_in); end
        n_tests++; if (writes_issued !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", writes_issued); end
        req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clock);
        req0_valid = 1'b1; req0_op = VEC_DATA_WRITE_VEC; req0_addr = 2'd1; req0_param = '0;
        req0_data = lanes(F9, F7, F5, F3);
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %0b expected 1", req0_ready); end
        n_tests++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready1: got %0b expected 0", req1_ready); end
        @(negedge clock);
        n_tests++; if (write_op !== VEC_DATA_WRITE_VEC) begin n_fail++; $display("FAIL single_op: got %0d expected 1", write_op); end
        n_tests++; if (write_addr !== 2'd1) begin n_fail++; $display("FAIL single_addr: got %0d expected 1", write_addr); end
        n_tests++; if (data_in !== lanes(F9, F7, F5, F3)) begin n_fail++; $display("FAIL single_data: got %0h expected %0h", data_in, lanes(F9, F7, F5, F3)); end
        req0_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (cache_mem[1] !== lanes(F9, F7, F5, F3)) begin n_fail++; $display("FAIL single_commit: got %0h expected %0h", cache_mem[1], lanes(F9, F7, F5, F3)); end
        n_tests++; if (writes_issued !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", writes_issued); end
        n_tests++; if (write_op !== VEC_DATA_WRITE_DISABLE) begin n_fail++; $display("FAIL single_idle_op: got %0d expected 0", write_op); end
    endtask

    task automatic test_scalar_hazard();
        @(negedge clock);
        req1_valid = 1'b1; req1_op = VEC_DATA_WRITE_SCALAR; req1_addr = 2'd1; req1_param = 2'd2;
        req1_data = lanes(F2, 32'd0, 32'd0, 32'd0);
        rd_addr = 2'd1;
        #1;
        n_tests++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL scalar_ready: got %0b%0b expected 10", req1_ready, req0_ready); end
        n_tests++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL scalar_hazard_before: got %0b expected 0", rd_hazard); end
        @(negedge clock);
        n_tests++; if (write_op !== VEC_DATA_WRITE_SCALAR || write_addr !== 2'd1 || write_param !== 2'd2) begin
            n_fail++; $display("FAIL scalar_port: got op=%0d addr=%0d param=%0d expected 2/1/2", write_op, write_addr, write_param); end
        n_tests++; if (rd_hazard !== 1'b1) begin n_fail++; $display("FAIL scalar_hazard_during: got %0b expected 1", rd_hazard); end
        req1_valid = 1'b0;
        rd_addr = 2'd2;
        #1;
        n_tests++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL scalar_hazard_other_addr: got %0b expected 0", rd_hazard); end
        rd_addr = 2'd1;
        @(negedge clock);
        n_tests++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL scalar_hazard_after: got %0b expected 0", rd_hazard); end
        n_tests++; if (cache_mem[1] !== lanes(F9, F7, F2, F3)) begin n_fail++; $display("FAIL scalar_commit: got %0h expected %0h", cache_mem[1], lanes(F9, F7, F2, F3)); end
        n_tests++; if (writes_issued !== 16'd2) begin n_fail++; $display("FAIL scalar_count: got %0d expected 2", writes_issued); end
    endtask

    task automatic test_disable_hold();
        logic [DW-1:0] data_a;
        logic [DW-1:0] data_b;
        data_a = lanes(32'h3F80_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        data_b = lanes(32'hBF80_0000, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666);
        @(negedge clock);
        req0_valid = 1'b1; req0_op = VEC_DATA_WRITE_DISABLE; req0_addr = 2'd3; req0_param = '0; req0_data = '0;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL disable_ready: got %0b expected 1", req0_ready); end
        @(negedge clock);
        n_tests++; if (write_op !== VEC_DATA_WRITE_DISABLE) begin n_fail++; $display("FAIL disable_op: got %0d expected 0", write_op); end
        n_tests++; if (writes_issued !== 16'd2) begin n_fail++; $display("FAIL disable_count: got %0d expected 2", writes_issued); end
        hold = 1'b1;
        req0_valid = 1'b1; req0_op = VEC_DATA_WRITE_VEC; req0_addr = 2'd0; req0_data = data_a;
        req1_valid = 1'b1; req1_op = VEC_DATA_WRITE_VEC; req1_addr = 2'd2; req1_param = '0; req1_data = data_b;
        #1;
        n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_c0: got %0b%0b expected 00", req0_ready, req1_ready); end
        for (int h = 1; h < 3; h++) begin
            @(negedge clock);
            #1;
            n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_c%0d: got %0b%0b expected 00", h, req0_ready, req1_ready); end
            n_tests++; if (write_op !== VEC_DATA_WRITE_DISABLE) begin n_fail++; $display("FAIL hold_op_c%0d: got %0d expected 0", h, write_op); end
        end
        @(negedge clock);
        hold = 1'b0;
        #1;
        n_tests++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL hold_release: got r1=%0b r0=%0b expected 1/0", req1_ready, req0_ready); end
        @(negedge clock);
        n_tests++; if (write_op !== VEC_DATA_WRITE_VEC || write_addr !== 2'd2 || data_in !== data_b) begin
            n_fail++; $display("FAIL hold_release_port: got op=%0d addr=%0d expected 1/2", write_op, write_addr); end
        req1_valid = 1'b0;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL hold_next_ready0: got %0b expected 1", req0_ready); end
        @(negedge clock);
        n_tests++; if (write_addr !== 2'd0 || data_in !== data_a) begin n_fail++; $display("FAIL hold_next_port: got addr=%0d expected 0", write_addr); end
        n_tests++; if (writes_issued !== 16'd3) begin n_fail++; $display("FAIL hold_count3: got %0d expected 3", writes_issued); end
        req0_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (writes_issued !== 16'd4) begin n_fail++; $display("FAIL hold_count4: got %0d expected 4", writes_issued); end
    endtask

    task automatic test_round_robin();
        int            exp_w  [4];
        logic [AW-1:0] a0     [4];
        logic [AW-1:0] a1     [4];
        logic [AW-1:0] exp_a  [4];
        exp_w = '{0, 1, 0, 1};
        a0    = '{2'd0, 2'd2, 2'd2, 2'd1};
        a1    = '{2'd1, 2'd1, 2'd3, 2'd3};
        exp_a = '{2'd0, 2'd1, 2'd2, 2'd3};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (k > 0) begin
                n_tests++; if (write_op !== VEC_DATA_WRITE_VEC || write_addr !== exp_a[k-1]) begin
                    n_fail++; $display("FAIL rr_port_%0d: got op=%0d addr=%0d expected 1/%0d", k-1, write_op, write_addr, exp_a[k-1]); end
            end
            req0_valid = 1'b1; req0_op = VEC_DATA_WRITE_VEC; req0_addr = a0[k]; req0_data = {4{32'hA000_0000 | 32'(k)}};
            req1_valid = 1'b1; req1_op = VEC_DATA_WRITE_VEC; req1_addr = a1[k]; req1_data = {4{32'hB000_0000 | 32'(k)}};
            #1;
            n_tests++; if (req0_ready !== (exp_w[k] == 0) || req1_ready !== (exp_w[k] == 1)) begin
                n_fail++; $display("FAIL rr_grant_%0d: got r0=%0b r1=%0b expected winner %0d", k, req0_ready, req1_ready, exp_w[k]); end
        end
        @(negedge clock);
        n_tests++; if (write_addr !== 2'd3) begin n_fail++; $display("FAIL rr_port_3: got addr=%0d expected 3", write_addr); end
        n_tests++; if (writes_issued !== 16'd3) begin n_fail++; $display("FAIL rr_count3: got %0d expected 3", writes_issued); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (writes_issued !== 16'd4) begin n_fail++; $display("FAIL rr_count4: got %0d expected 4", writes_issued); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] data_x;
        logic [DW-1:0] data_y;
        logic [DW-1:0] mem3;
        data_x = {4{32'hDEAD_0003}};
        data_y = {4{32'hBEEF_0000}};
        @(negedge clock);
        req0_valid = 1'b1; req0_op = VEC_DATA_WRITE_VEC; req0_addr = 2'd3; req0_data = data_x;
        #1;
        n_tests++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready0: got %0b expected 1", req0_ready); end
        @(negedge clock);
        n_tests++; if (write_op !== VEC_DATA_WRITE_VEC || write_addr !== 2'd3) begin n_fail++; $display("FAIL rmid_pending: got op=%0d addr=%0d expected 1/3", write_op, write_addr); end
        mem3 = cache_mem[3];
        reset = 1'b1; req0_valid = 1'b0; rd_addr = 2'd3;
        req1_valid = 1'b1; req1_op = VEC_DATA_WRITE_VEC; req1_addr = 2'd0; req1_param = '0; req1_data = data_y;
        #1;
        n_tests++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready_in_reset: got %0b%0b expected 00", req0_ready, req1_ready); end
        n_tests++; if (rd_hazard !== 1'b0) begin n_fail++; $display("FAIL rmid_hazard_in_reset: got %0b expected 0", rd_hazard); end
        @(negedge clock);
        n_tests++; if (cache_mem[3] !== mem3) begin n_fail++; $display("FAIL rmid_dropped: got %0h expected %0h", cache_mem[3], mem3); end
        n_tests++; if (write_op !== VEC_DATA_WRITE_DISABLE || write_addr !== '0 || write_param !== '0 || data_in !== '0) begin
            n_fail++; $display("FAIL rmid_outputs: got op=%0d addr=%0d param=%0d data=%0h expected all 0", write_op, write_addr, write_param, data_in); end
        n_tests++; if (writes_issued !== 16'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", writes_issued); end
        reset = 1'b0;
        #1;
        n_tests++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant: got %0b expected 1", req1_ready); end
        @(negedge clock);
        n_tests++; if (write_op !== VEC_DATA_WRITE_VEC || write_addr !== 2'd0 || data_in !== data_y) begin
            n_fail++; $display("FAIL rmid_regrant_port: got op=%0d addr=%0d expected 1/0", write_op, write_addr); end
        req1_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (writes_issued !== 16'd1) begin n_fail++; $display("FAIL rmid_count_after: got %0d expected 1", writes_issued); end
        n_tests++; if (cache_mem[0] !== data_y) begin n_fail++; $display("FAIL rmid_commit: got %0h expected %0h", cache_mem[0], data_y); end
    endtask

    task automatic test_wrap();
        @(negedge clock);
        force dut.writes_issued_q = 16'hFFFF;
        @(negedge clock);
        release dut.writes_issued_q;
        req0_valid = 1'b1; req0_op = VEC_DATA_WRITE_VEC; req0_addr = 2'd2; req0_data = {4{32'h0000_0F0F}};
        #1;
        n_tests++; if (writes_issued !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset: got %0h expected ffff", writes_issued); end
        @(negedge clock);
        n_tests++; if (writes_issued !== 16'hFFFF || write_op !== VEC_DATA_WRITE_VEC) begin
            n_fail++; $display("FAIL wrap_before: got count=%0h op=%0d expected ffff/1", writes_issued, write_op); end
        req0_valid = 1'b0;
        @(negedge clock);
        n_tests++; if (writes_issued !== 16'h0000) begin n_fail++; $display("FAIL wrap_after: got %0h expected 0", writes_issued); end
    endtask

    // Randomized traffic against a transaction-level model: requests are
    // granted by the round-robin rule, each grant becomes the port content for
    // one cycle, and every non-DISABLE port cycle updates the expected memory.
    task automatic test_random(input int n_cycles);
        logic          m_valid [2];
        logic [1:0]    m_op    [2];
        logic [AW-1:0] m_addr  [2];
        logic [AW-1:0] m_param [2];
        logic [DW-1:0] m_data  [2];
        logic [DW-1:0] e_mem   [WIDTH];
        logic          m_last;
        logic          m_hold;
        logic [AW-1:0] m_rd;
        logic [1:0]    e_op;
        logic [AW-1:0] e_addr, e_param;
        logic [DW-1:0] e_data;
        logic [15:0]   e_count;
        int            win;
        int            prev_win;

        apply_reset();
        m_last = 1'b1; e_op = VEC_DATA_WRITE_DISABLE; e_addr = '0; e_param = '0; e_data = '0; e_count = '0;
        prev_win = -1;
        m_valid = '{1'b0, 1'b0};
        for (int a = 0; a < WIDTH; a++) e_mem[a] = cache_mem[a];

        for (int c = 0; c < n_cycles; c++) begin
            n_tests++; if (write_op !== e_op || write_addr !== e_addr || write_param !== e_param || data_in !== e_data) begin
                n_fail++; $display("FAIL rand_port_c%0d: got op=%0d addr=%0d param=%0d expected %0d/%0d/%0d", c, write_op, write_addr, write_param, e_op, e_addr, e_param); end
            n_tests++; if (writes_issued !== e_count) begin n_fail++; $display("FAIL rand_count_c%0d: got %0d expected %0d", c, writes_issued, e_count); end

            for (int r = 0; r < 2; r++) begin
                if (!m_valid[r] || prev_win == r) begin
                    m_valid[r] = ($urandom_range(0, 3) != 0);
                    m_op[r]    = 2'($urandom_range(0, 2));
                    m_addr[r]  = AW'($urandom);
                    m_param[r] = AW'($urandom);
                    m_data[r]  = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            m_hold = ($urandom_range(0, 4) == 0);
            m_rd   = AW'($urandom);

            hold = m_hold; rd_addr = m_rd;
            req0_valid = m_valid[0]; req0_op = m_op[0]; req0_addr = m_addr[0]; req0_param = m_param[0]; req0_data = m_data[0];
            req1_valid = m_valid[1]; req1_op = m_op[1]; req1_addr = m_addr[1]; req1_param = m_param[1]; req1_data = m_data[1];
            #1;

            win = -1;
            if (!m_hold) begin
                if (m_valid[0] && m_valid[1]) win = m_last ? 0 : 1;
                else if (m_valid[0])          win = 0;
                else if (m_valid[1])          win = 1;
            end
            n_tests++; if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
                n_fail++; $display("FAIL rand_grant_c%0d: got r0=%0b r1=%0b expected winner %0d", c, req0_ready, req1_ready, win); end
            n_tests++; if (rd_hazard !== ((e_op != VEC_DATA_WRITE_DISABLE) && (e_addr == m_rd))) begin
                n_fail++; $display("FAIL rand_hazard_c%0d: got %0b", c, rd_hazard); end

            if (e_op != VEC_DATA_WRITE_DISABLE) e_count++;
            if (e_op == VEC_DATA_WRITE_VEC)         e_mem[e_addr] = e_data;
            else if (e_op == VEC_DATA_WRITE_SCALAR) e_mem[e_addr][32*e_param +: 32] = e_data[31:0];
            if (win >= 0) begin
                m_last  = (win == 1);
                e_op    = m_op[win];
                e_addr  = m_addr[win];
                e_param = m_param[win];
                e_data  = m_data[win];
            end else begin
                e_op = VEC_DATA_WRITE_DISABLE;
            end
            prev_win = win;
            @(negedge clock);
        end

        req0_valid = 1'b0; req1_valid = 1'b0; hold = 1'b0;
        if (e_op != VEC_DATA_WRITE_DISABLE) e_count++;
        if (e_op == VEC_DATA_WRITE_VEC)         e_mem[e_addr] = e_data;
        else if (e_op == VEC_DATA_WRITE_SCALAR) e_mem[e_addr][32*e_param +: 32] = e_data[31:0];
        @(negedge clock);
        n_tests++; if (writes_issued !== e_count) begin n_fail++; $display("FAIL rand_count_final: got %0d expected %0d", writes_issued, e_count); end
        for (int a = 0; a < WIDTH; a++) begin
            n_tests++; if (cache_mem[a] !== e_mem[a]) begin n_fail++; $display("FAIL rand_mem_%0d: got %0h expected %0h", a, cache_mem[a], e_mem[a]); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_scalar_hazard();
        test_disable_hold();
        test_round_robin();
        test_reset_mid();
        test_wrap();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
